// File: rtl/minibyte_mem_arbiter.sv
// Two-port (CPU / debug) arbiter onto the MiniByte ROM, IO register and data RAM.
// Define MINIBYTE_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin.
module minibyte_mem_arbiter #(
    parameter int         RAM_WAIT = 1,
    parameter logic [7:0] IO_ADDR  = 8'h40,
    parameter logic [7:0] ROM_TOP  = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       ram_en,
    output logic       ram_we,
    output logic [6:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] io_out,
    output logic       busy,
    output logic       grant_dbg
);

    localparam logic [2:0] WAIT_N = 3'(RAM_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {R_ROM, R_IO, R_RAM, R_UNM} region_t;

    state_t     state_q, state_d;
    region_t    region;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [2:0] cnt_q;
    logic       any_req;
    logic       pick_dbg;
    logic       rd_load;
    logic [7:0] rd_val;

    assign any_req = cpu_req | dbg_req;

`ifdef MINIBYTE_ARB_CPU_PRIORITY_EN
    assign pick_dbg = dbg_req & ~cpu_req;
`else
    // On a tie the port that did not own the last transaction wins.
    assign pick_dbg = dbg_req & (~cpu_req | ~grant_dbg);
`endif

    always_comb begin
        if (addr_q <= ROM_TOP)
            region = R_ROM;
        else if (addr_q == IO_ADDR)
            region = R_IO;
        else if (addr_q <= 8'h7F)
            region = R_RAM;
        else
            region = R_UNM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != S_IDLE);
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        rom_addr  = 6'h00;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q[6:0];
        ram_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (region == R_ROM)
                    rom_addr = addr_q[5:0];
                if (region == R_RAM) begin
                    ram_en = 1'b1;
                    ram_we = we_q;
                end
                if (region == R_RAM && !we_q)
                    state_d = S_WAIT;
                else
                    state_d = S_RESP;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_N)
                    state_d = S_RESP;
            end
            S_RESP: begin
                cpu_ack = ~grant_dbg;
                dbg_ack = grant_dbg;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        unique case (region)
            R_ROM: rd_val = rom_data;
            R_IO:  rd_val = io_out;
            R_RAM: rd_val = ram_rdata;
            R_UNM: rd_val = 8'h00;
            default: rd_val = 8'h00;
        endcase
        rd_load = 1'b0;
        if (state_q == S_ISSUE && !we_q && region != R_RAM)
            rd_load = 1'b1;
        if (state_q == S_WAIT && cnt_q == WAIT_N)
            rd_load = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            cnt_q     <= 3'd0;
            grant_dbg <= 1'b1;
            io_out    <= 8'h00;
            cpu_rdata <= 8'h00;
            dbg_rdata <= 8'h00;
        end else begin
            if (state_q == S_IDLE && any_req) begin
                grant_dbg <= pick_dbg;
                we_q      <= pick_dbg ? dbg_we    : cpu_we;
                addr_q    <= pick_dbg ? dbg_addr  : cpu_addr;
                wdata_q   <= pick_dbg ? dbg_wdata : cpu_wdata;
            end
            // ISSUE counts as the first RAM wait cycle.
            if (state_q == S_ISSUE)
                cnt_q <= 3'd1;
            else if (state_q == S_WAIT && cnt_q != WAIT_N)
                cnt_q <= cnt_q + 3'd1;
            if (state_q == S_ISSUE && we_q && region == R_IO)
                io_out <= wdata_q;
            if (rd_load) begin
                if (grant_dbg)
                    dbg_rdata <= rd_val;
                else
                    cpu_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_minibyte_mem_arbiter.sv
// Scoreboard bench for minibyte_mem_arbiter: directed requests, ack monitor.
// Built with RAM_WAIT=2 and an identity ROM (data = address).
module tb_minibyte_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dbg_req, dbg_we, dbg_ack;
    logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       ram_en, ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] io_out;
    logic       busy, grant_dbg;

    minibyte_mem_arbiter #(.RAM_WAIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_out(io_out), .busy(busy), .grant_dbg(grant_dbg)
    );

    always #5 clk = ~clk;

    assign rom_data = {2'b00, rom_addr};

    // RAM model: read data is valid exactly two cycles after ram_en.
    logic [7:0] mem [128];
    logic [7:0] st0, st1;
    assign ram_rdata = st1;
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        st0 = 8'hEE;
        st1 = 8'hEE;
    end
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        st0 <= (ram_en && !ram_we) ? mem[ram_addr] : 8'hEE;
        st1 <= st0;
    end

    typedef struct {
        bit         dbg;
        bit         chk;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ack && dbg_ack) begin
            check("both_acks", 1, 0);
        end else if (cpu_ack || dbg_ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {31'd0, dbg_ack}, 32'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_port", {31'd0, dbg_ack}, {31'd0, e.dbg});
                if (e.chk)
                    check("rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.data);
            end
        end
    end

    logic [5:0] iss_rom_addr;
    logic       iss_ram_en, iss_ram_we;
    logic [6:0] iss_ram_addr;
    int         pulses;

    task automatic do_req(input bit d, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_data,
                          input int exp_lat);
        int  cnt;
        bit  got;
        exp_t e;
        e.dbg  = d;
        e.chk  = !we;
        e.data = exp_data;
        q.push_back(e);
        if (d) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        cnt = 0;
        got = 0;
        pulses = 0;
        while (!got && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (ram_en) pulses++;
            if (cnt == 1) begin
                iss_rom_addr = rom_addr;
                iss_ram_en   = ram_en;
                iss_ram_we   = ram_we;
                iss_ram_addr = ram_addr;
            end
            if (d ? dbg_ack : cpu_ack) got = 1;
        end
        check("latency", got ? cnt : -1, exp_lat);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dbg_ack", dbg_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_io_out", io_out, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_dbg", grant_dbg, 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(0, 0, 8'h01, 8'h00, 8'h01, 2);
        check("rom_addr_issue", iss_rom_addr, 6'h01);
        check("grant_cpu", grant_dbg, 0);
        do_req(0, 0, 8'h3F, 8'h00, 8'h3F, 2);

        do_req(0, 1, 8'h40, 8'hA5, 8'h00, 2);
        check("io_after_write", io_out, 8'hA5);
        do_req(0, 0, 8'h40, 8'h00, 8'hA5, 2);
        do_req(0, 1, 8'h10, 8'h33, 8'h00, 2);
        check("rom_write_io", io_out, 8'hA5);
        check("rom_write_noram", pulses, 0);

        do_req(0, 1, 8'h78, 8'hDE, 8'h00, 2);
        check("ramw_en", iss_ram_en, 1);
        check("ramw_we", iss_ram_we, 1);
        check("ramw_addr", iss_ram_addr, 7'h78);
        check("ramw_pulses", pulses, 1);
        do_req(0, 0, 8'h78, 8'h00, 8'hDE, 4);
        check("ramr_we", iss_ram_we, 0);
        check("ramr_pulses", pulses, 1);

        do_req(1, 1, 8'h7F, 8'h9C, 8'h00, 2);
        do_req(1, 0, 8'h7F, 8'h00, 8'h9C, 4);
        check("grant_dbg", grant_dbg, 1);
        check("loser_rdata_hold", cpu_rdata, 8'hDE);
        do_req(1, 0, 8'h41, 8'h00, 8'h00, 4);

        do_req(1, 0, 8'h90, 8'h00, 8'h00, 2);
        check("unm_noram", pulses, 0);
        check("unm_io", io_out, 8'hA5);
        do_req(1, 1, 8'hC0, 8'h11, 8'h00, 2);
        check("unmw_io", io_out, 8'hA5);
        check("unmw_noram", pulses, 0);
        do_req(0, 0, 8'h80, 8'h00, 8'h00, 2);

        // Both ports requesting continuously out of reset.
        rst_n = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h0A;
        for (int i = 0; i < 4; i++) begin
`ifdef MINIBYTE_ARB_CPU_PRIORITY_EN
            e.dbg = 0;
`else
            e.dbg = (i % 2 == 1);
`endif
            e.chk  = 1;
            e.data = e.dbg ? 8'h0A : 8'h05;
            q.push_back(e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) n++;
        end
        cpu_req = 0;
        dbg_req = 0;
        check("rr_acks", n, 4);
        @(negedge clk);

        // Reset while a RAM read sits in WAIT.
        do_req(0, 1, 8'h40, 8'h5A, 8'h00, 2);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h78;
        repeat (2) @(negedge clk);
        check("wait_busy", busy, 1);
        rst_n = 1'b0;
        cpu_req = 0;
        #1;
        check("abort_io", io_out, 0);
        check("abort_busy", busy, 0);
        check("abort_grant", grant_dbg, 1);
        check("abort_cpu_rdata", cpu_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) n++;
        end
        check("abort_no_ack", n, 0);
        do_req(0, 0, 8'h78, 8'h00, 8'hDE, 4);

        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/minibyte_mem_arbiter.md
Name: minibyte_mem_arbiter

Overview:
- Shares the MiniByte 8-bit memory space between two requesters: the CPU core (port C) and a debug/loader port (port D).
- Decodes addresses into four regions: the 64-byte program ROM, the output port register at 0x40, the external data RAM, and unmapped space.
- Sequences each access with a small FSM and one-cycle-pulse acks.
- Sits between the CPU core, the debug interface, the demo ROM, the data RAM macro and the user output pins.

Parameters:
- RAM_WAIT, 1, RAM read latency in cycles after ram_en (legal 1..4).
- IO_ADDR, 8'h40, address of the output port register.
- ROM_TOP, 8'h3F, last ROM address; the ROM region is 0x00..ROM_TOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  CPU write enable (1=write).
- cpu_addr  in  8  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  8  CPU read data; valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_addr[8], dbg_wdata[8]  in  debug request, same semantics as the cpu_* inputs.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- dbg_rdata  out  8  debug read data; valid while dbg_ack=1.
- rom_addr  out  6  ROM address (combinational ROM).
- rom_data  in  8  ROM read data.
- ram_en  out  1  RAM access strobe, one cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  7  RAM address (= addr[6:0]).
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid RAM_WAIT cycles after ram_en.
- io_out  out  8  output port register contents.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_dbg  out  1  owner of the current or last transaction (1=debug).

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE.
  - All acks=0; cpu_rdata, dbg_rdata, io_out=8'h00.
  - ram_en=0, ram_we=0, rom_addr=0, busy=0.
  - grant_dbg=1, so the first round-robin winner is the CPU.
  - A transaction in flight is abandoned with no ack.
- Address decode:
  - ROM: addr<=ROM_TOP.
  - IO: addr==IO_ADDR.
  - RAM: ROM_TOP<addr<=8'h7F, excluding IO_ADDR.
  - UNMAPPED: addr>=8'h80.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner; latch its we/addr/wdata; set grant_dbg; go ISSUE.
  - Arbitration is round-robin: on a tie, the port not granted last wins. A lone requester always wins.
- ISSUE, one cycle, action by region:
  - ROM: rom_addr=addr[5:0]; capture rom_data at the clock edge. Writes to ROM are dropped but still acked.
  - IO: a write loads io_out; a read returns io_out.
  - UNMAPPED: a read returns 8'h00; a write is dropped.
  - RAM: ram_en=1 for this cycle only, with ram_we/ram_addr/ram_wdata driven. A RAM write goes to RESP. A RAM read goes to WAIT.
  - All regions other than a RAM read go to RESP.
- WAIT:
  - Count RAM_WAIT cycles, including the ISSUE cycle as cycle 1.
  - Capture ram_rdata on the final count, then go RESP.
  - With RAM_WAIT=1, WAIT lasts one cycle.
- RESP:
  - Pulse the winner's ack for exactly one cycle, with the winner's rdata registered and valid.
  - The loser's ack stays 0; the loser's rdata holds its previous value.
  - Go IDLE.
- Latency (req first seen high in IDLE at edge N):
  - ack at N+2 for ROM, IO, UNMAPPED and RAM writes.
  - ack at N+2+RAM_WAIT for RAM reads.
- Handshake rules:
  - Requesters hold req and request fields stable until ack.
  - req may fall in the ack cycle. If req is still high in the cycle after ack, that is a new request.
  - req dropping mid-transaction does not cancel it; the ack still pulses.
  - Requests arriving while busy=1 wait in IDLE arbitration; none are queued internally.
- An io_out write takes effect at the ISSUE edge. A read of IO in the same transaction sees the old value; reads in later transactions see the new one.
- Back-to-back: minimum 3 cycles per non-RAM-read transaction. IDLE is always visited between transactions.

Optional Feature:
- Macro: MINIBYTE_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. The CPU always wins a tie; the debug port is granted only when cpu_req=0 in IDLE. grant_dbg still reports the owner.
- Undefined: round-robin as described above.

Test Plan:
- Reset then cpu_req read addr 0x01 with rom_data=8'h01 -> cpu_ack pulses at N+2 with cpu_rdata=8'h01; rom_addr=6'h01 in ISSUE; dbg_ack stays 0.
- CPU write 0x40 data 0xA5, then CPU read 0x40 -> io_out=8'hA5 after the ISSUE edge; read returns 8'hA5. Write to 0x10 -> acked, no port change.
- CPU write 0x78=0xDE, then read 0x78 with RAM_WAIT=2 -> one-cycle ram_en pulse with ram_addr=7'h78, ram_we=1 on the write; read ack at N+4 with rdata=8'hDE.
- cpu_req and dbg_req both held high continuously from reset -> grants alternate C,D,C,D. With MINIBYTE_ARB_CPU_PRIORITY_EN the debug port is never granted.
- dbg read 0x90 -> dbg_ack at N+2 with dbg_rdata=8'h00; no ram_en and no io change.
- rst_n low during WAIT of a RAM read -> no ack, io_out=8'h00, FSM returns to IDLE; a new request after release completes normally.
